// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, word-addressed instruction memory with a
// program-load write port, downstream stall, PC-relative redirect and out-of-range halt.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          branch_taken,
  input  logic [31:0]                   branch_pc,
  input  logic [15:0]                   branch_imm,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  output logic [31:0]                   machinecode,
  output logic [31:0]                   instr_pc,
  output logic                          instr_valid,
  output logic                          halted
);

  localparam int unsigned AW       = $clog2(IMEM_DEPTH);
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * 4);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t         state;
  logic [31:0]    pc_q;
  logic [31:0]    imem [IMEM_DEPTH];

  logic [31:0]    branch_target_c;
  logic           target_in_range_c;
  logic           fetch_in_range_c;
  logic [AW-1:0]  fetch_idx_c;

  // Branch target is relative to the instruction after the branch, offset in words.
  assign branch_target_c   = branch_pc + 32'd4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign target_in_range_c = (branch_target_c < PC_LIMIT);
  assign fetch_in_range_c  = (pc_q < PC_LIMIT);
  assign fetch_idx_c       = pc_q[AW+1:2];

  // Program load port; not reset, and a same-edge fetch sees the old word.
  always_ff @(posedge clk) begin
    if (load_en) begin
      imem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc_q        <= PC_RESET;
      machinecode <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (branch_taken) begin
      // Redirect squashes the wrong-path word; only an in-range target leaves HALT.
      pc_q        <= branch_target_c;
      instr_valid <= 1'b0;
      if ((state == HALT) && target_in_range_c) begin
        state  <= RUN;
        halted <= 1'b0;
      end
    end else if (!stall && (state == RUN)) begin
      if (fetch_in_range_c) begin
        machinecode <= imem[fetch_idx_c];
        instr_pc    <= pc_q;
        instr_valid <= 1'b1;
        pc_q        <= pc_q + 32'd4;
      end else begin
        state       <= HALT;
        machinecode <= 32'h0;
        instr_valid <= 1'b0;
        halted      <= 1'b1;
      end
    end
  end

endmodule
